line_raster_stream: RTL and testbench
=====================================

Name: line_raster_stream

Overview:
- Parametrised successor to the fixed 4-bit Bresenham stepper.
- Rasterises one line segment from (x0,y0) to (x1,y1), both endpoints inclusive, in all octants.
- Emits one pixel coordinate per valid/ready handshake, with start/abort control, a last-point flag, a point index and a done pulse.
- Sits between the coordinate/command front end and any pixel consumer (frame-buffer writer, LED-matrix driver, uo_out serialiser).

Parameters:
- COORD_W, 4, width of each coordinate (unsigned, 2..12 supported).
- ERR_W, COORD_W+3, width of the signed error accumulator and its doubled copy e2; must not be overridden smaller.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- abort  in  1  cancel current line; sampled in RUN.
- x0  in  COORD_W  start X, captured on accepted start.
- y0  in  COORD_W  start Y, captured on accepted start.
- x1  in  COORD_W  end X, captured on accepted start.
- y1  in  COORD_W  end Y, captured on accepted start.
- busy  out  1  high in RUN.
- pt_valid  out  1  current point is valid.
- pt_ready  in  1  consumer accepts the point.
- pt_x  out  COORD_W  current point X.
- pt_y  out  COORD_W  current point Y.
- pt_last  out  1  current point is the endpoint.
- pt_idx  out  COORD_W+1  zero-based index of the current point.
- done  out  1  one-cycle pulse after the last point is accepted.

Behaviour:
- Reset values, applied on any cycle including mid-line: state IDLE; busy, pt_valid, pt_last and done = 0; pt_x, pt_y, pt_idx = 0.
- States: IDLE and RUN only.
- IDLE -> RUN on start=1 && abort=0. abort=1 in IDLE suppresses start.
- On entry to RUN, capture the endpoints and compute:
  - dx = |x1-x0|, and dy = -|y1-y0|, both sign-extended to ERR_W;
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1;
  - err = dx+dy;
  - pt = (x0,y0), pt_idx = 0.
- Latency: start accepted in cycle N gives pt_valid=1 with the first point in cycle N+1.
- In RUN, pt_valid=1 continuously.
- pt_last = (pt_x==x1 && pt_y==y1), computed from registered state.
- While pt_valid && !pt_ready: pt_x, pt_y, pt_last, pt_idx and err hold exactly (stall).
- On handshake (pt_valid && pt_ready) with pt_last=0, apply one step in a single cycle:
  - e2 = 2*err;
  - if e2 >= dy: err += dy, x += sx;
  - if e2 <= dx: err += dx, y += sy;
  - both updates may apply in the same cycle; err uses the sum of both deltas;
  - pt_idx += 1.
- On handshake with pt_last=1: RUN -> IDLE, pt_valid drops next cycle, done=1 for exactly that one cycle.
- Abort in RUN: go to IDLE next cycle, pt_valid=0, done stays 0, and any same-cycle handshake is discarded. Abort has priority over the handshake.
- start while busy is ignored; endpoint inputs are not re-sampled mid-line.
- Degenerate line (x0==x1 && y0==y1): exactly one point, pt_last=1 immediately, then done.
- Total points = max(|x1-x0|, |y1-y0|) + 1. pt_idx of the last point = max(...), which fits COORD_W+1 bits with no wrap.
- Coordinate arithmetic is COORD_W-bit. Steps never leave the bounding box, so no wrap-around is possible.
- Handshake path: no combinational path from pt_ready to pt_valid.

Decomposition:
- Package line_raster_pkg holds:
  - state enum {IDLE, RUN};
  - a function for ERR_W from COORD_W;
  - a sign-extend/absolute-difference helper function.
- One combinational sub-module, bresenham_step.
  - Inputs: err, dx, dy, sx, sy, x, y.
  - Outputs: next err, x, y.
  - Unit-testable in isolation.
- The top level holds the FSM, the registers, the handshake and the index counter.

Test Plan:
- Shallow line, COORD_W=4: (0,0)->(3,1), pt_ready=1 -> points (0,0),(1,0),(2,1),(3,1); idx 0..3; pt_last only on (3,1); done pulses 1 cycle later; pt_valid first at N+1.
- Steep line: (0,0)->(1,3) -> points (0,0),(0,1),(1,2),(1,3).
- Negative direction with stall: (5,5)->(2,5), pt_ready toggling 1,0,0,1,... -> points 5,4,3,2 at y=5, each held stable across stall cycles; no duplicates, no skips.
- Degenerate line and start-while-busy: (7,7)->(7,7) -> single point with pt_last=1 and idx 0, then done. A start pulsed during a long line changes nothing.
- Abort and reset: abort after the 2nd point of (0,0)->(15,9) -> IDLE next cycle, no done. rst mid-line -> all outputs 0 next cycle. A new start afterwards runs cleanly.
- Full-span line, COORD_W=8: (255,0)->(0,255) -> 256 points ending at (0,255); pt_idx reaches 255; the point set matches a reference model.

Source files
------------

// File: rtl/line_raster_pkg.sv
// rtl/line_raster_pkg.sv - shared types and helpers for the line rasteriser
package line_raster_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Widest coordinate the helpers are sized for
  localparam int COORD_MAX_W = 12;

  // Two extra bits cover the doubled error plus a sign bit with headroom
  function automatic int calc_err_w(input int coord_w);
    return coord_w + 3;
  endfunction

  function automatic logic [COORD_MAX_W-1:0] abs_diff(
    input logic [COORD_MAX_W-1:0] a,
    input logic [COORD_MAX_W-1:0] b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// rtl/bresenham_step.sv - one combinational Bresenham step (error update plus x/y advance)
module bresenham_step
  import line_raster_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int ERR_W   = calc_err_w(COORD_W)
) (
  input  logic signed [ERR_W-1:0]   err,
  input  logic signed [ERR_W-1:0]   dx,
  input  logic signed [ERR_W-1:0]   dy,
  input  logic                      sx_neg,
  input  logic                      sy_neg,
  input  logic        [COORD_W-1:0] x,
  input  logic        [COORD_W-1:0] y,
  output logic signed [ERR_W-1:0]   err_next,
  output logic        [COORD_W-1:0] x_next,
  output logic        [COORD_W-1:0] y_next
);

  logic signed [ERR_W-1:0] e2;
  logic signed [ERR_W-1:0] delta_x;
  logic signed [ERR_W-1:0] delta_y;
  logic                    step_x;
  logic                    step_y;

  always_comb begin
    e2      = err <<< 1;
    step_x  = (e2 >= dy);
    step_y  = (e2 <= dx);
    // Diagonal moves fold both error deltas into one update
    delta_x = step_x ? dy : {ERR_W{1'b0}};
    delta_y = step_y ? dx : {ERR_W{1'b0}};
    err_next = err + delta_x + delta_y;
    x_next   = x;
    y_next   = y;
    if (step_x) begin
      x_next = sx_neg ? (x - 1'b1) : (x + 1'b1);
    end
    if (step_y) begin
      y_next = sy_neg ? (y - 1'b1) : (y + 1'b1);
    end
  end

endmodule

// File: rtl/line_raster_stream.sv
// rtl/line_raster_stream.sv - streams the pixels of one line segment, one per valid/ready handshake
module line_raster_stream
  import line_raster_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int ERR_W   = calc_err_w(COORD_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic               pt_valid,
  input  logic               pt_ready,
  output logic [COORD_W-1:0] pt_x,
  output logic [COORD_W-1:0] pt_y,
  output logic               pt_last,
  output logic [COORD_W:0]   pt_idx,
  output logic               done
);

  localparam int IDX_W = COORD_W + 1;

  state_e                    state_q, state_d;
  logic        [COORD_W-1:0] x_end_q, x_end_d;
  logic        [COORD_W-1:0] y_end_q, y_end_d;
  logic        [COORD_W-1:0] pt_x_q, pt_x_d;
  logic        [COORD_W-1:0] pt_y_q, pt_y_d;
  logic signed [ERR_W-1:0]   dx_q, dx_d;
  logic signed [ERR_W-1:0]   dy_q, dy_d;
  logic signed [ERR_W-1:0]   err_q, err_d;
  logic                      sx_neg_q, sx_neg_d;
  logic                      sy_neg_q, sy_neg_d;
  logic        [IDX_W-1:0]   idx_q, idx_d;
  logic                      done_q, done_d;

  logic signed [ERR_W-1:0]   dx_in;
  logic signed [ERR_W-1:0]   dy_in;
  logic signed [ERR_W-1:0]   step_err;
  logic        [COORD_W-1:0] step_x;
  logic        [COORD_W-1:0] step_y;
  logic                      at_end;

  assign dx_in  = ERR_W'(abs_diff(COORD_MAX_W'(x1), COORD_MAX_W'(x0)));
  assign dy_in  = -ERR_W'(abs_diff(COORD_MAX_W'(y1), COORD_MAX_W'(y0)));
  assign at_end = (pt_x_q == x_end_q) && (pt_y_q == y_end_q);

  bresenham_step #(
    .COORD_W (COORD_W),
    .ERR_W   (ERR_W)
  ) u_step (
    .err      (err_q),
    .dx       (dx_q),
    .dy       (dy_q),
    .sx_neg   (sx_neg_q),
    .sy_neg   (sy_neg_q),
    .x        (pt_x_q),
    .y        (pt_y_q),
    .err_next (step_err),
    .x_next   (step_x),
    .y_next   (step_y)
  );

  always_comb begin
    state_d  = state_q;
    x_end_d  = x_end_q;
    y_end_d  = y_end_q;
    pt_x_d   = pt_x_q;
    pt_y_d   = pt_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    idx_d    = idx_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = RUN;
          x_end_d  = x1;
          y_end_d  = y1;
          pt_x_d   = x0;
          pt_y_d   = y0;
          dx_d     = dx_in;
          dy_d     = dy_in;
          err_d    = dx_in + dy_in;
          sx_neg_d = !(x0 < x1);
          sy_neg_d = !(y0 < y1);
          idx_d    = '0;
        end
      end
      RUN: begin
        // Abort wins over a same-cycle handshake and never raises done
        if (abort) begin
          state_d = IDLE;
        end else if (pt_ready) begin
          if (at_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            err_d  = step_err;
            pt_x_d = step_x;
            pt_y_d = step_y;
            idx_d  = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_end_q  <= '0;
      y_end_q  <= '0;
      pt_x_q   <= '0;
      pt_y_q   <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_end_q  <= x_end_d;
      y_end_q  <= y_end_d;
      pt_x_q   <= pt_x_d;
      pt_y_q   <= pt_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign pt_valid = (state_q == RUN);
  assign pt_last  = (state_q == RUN) && at_end;
  assign pt_x     = pt_x_q;
  assign pt_y     = pt_y_q;
  assign pt_idx   = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_line_raster_stream.sv
// tb/tb_line_raster_stream.sv - directed bench for line_raster_stream at 4- and 8-bit coordinates
module tb_line_raster_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, pt_ready;
  logic [3:0] x0_4, y0_4, x1_4, y1_4;
  logic [7:0] x0_8, y0_8, x1_8, y1_8;

  logic       busy4, valid4, last4, done4;
  logic [3:0] ptx4, pty4;
  logic [4:0] idx4;
  logic       busy8, valid8, last8, done8;
  logic [7:0] ptx8, pty8;
  logic [8:0] idx8;

  int checks = 0;
  int errors = 0;
  bit use4;
  int xs[4];
  int ys[4];

  line_raster_stream #(.COORD_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x0(x0_4), .y0(y0_4), .x1(x1_4), .y1(y1_4),
    .busy(busy4), .pt_valid(valid4), .pt_ready(pt_ready),
    .pt_x(ptx4), .pt_y(pty4), .pt_last(last4), .pt_idx(idx4), .done(done4)
  );

  line_raster_stream #(.COORD_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x0(x0_8), .y0(y0_8), .x1(x1_8), .y1(y1_8),
    .busy(busy8), .pt_valid(valid8), .pt_ready(pt_ready),
    .pt_x(ptx8), .pt_y(pty8), .pt_last(last8), .pt_idx(idx8), .done(done8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pt(input string tag, input int ex, input int ey, input int eidx, input bit elast);
    chk({tag, ".valid8"}, 32'(valid8), 32'(1));
    chk({tag, ".x8"},     32'(ptx8),   32'(ex));
    chk({tag, ".y8"},     32'(pty8),   32'(ey));
    chk({tag, ".idx8"},   32'(idx8),   32'(eidx));
    chk({tag, ".last8"},  32'(last8),  32'(elast));
    if (use4) begin
      chk({tag, ".valid4"}, 32'(valid4), 32'(1));
      chk({tag, ".x4"},     32'(ptx4),   32'(ex));
      chk({tag, ".y4"},     32'(pty4),   32'(ey));
      chk({tag, ".idx4"},   32'(idx4),   32'(eidx));
      chk({tag, ".last4"},  32'(last4),  32'(elast));
    end
  endtask

  task automatic chk_state(input string tag, input bit ebusy, input bit edone);
    chk({tag, ".busy8"},  32'(busy8),  32'(ebusy));
    chk({tag, ".valid8"}, 32'(valid8), 32'(ebusy));
    chk({tag, ".done8"},  32'(done8),  32'(edone));
    if (use4) begin
      chk({tag, ".busy4"},  32'(busy4),  32'(ebusy));
      chk({tag, ".valid4"}, 32'(valid4), 32'(ebusy));
      chk({tag, ".done4"},  32'(done4),  32'(edone));
    end
  endtask

  task automatic set_coords(input int a, input int b, input int c, input int d);
    x0_8 = 8'(a); y0_8 = 8'(b); x1_8 = 8'(c); y1_8 = 8'(d);
    x0_4 = 4'(a); y0_4 = 4'(b); x1_4 = 4'(c); y1_4 = 4'(d);
  endtask

  task automatic start_line(input int a, input int b, input int c, input int d);
    set_coords(a, b, c, d);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Four-point line with pt_ready held high, expected points in xs/ys
  task automatic run4(input string tag);
    for (int i = 0; i < 4; i++) begin
      check_pt($sformatf("%s.p%0d", tag, i), xs[i], ys[i], i, (i == 3));
      tick();
    end
    chk_state({tag, ".done"}, 1'b0, 1'b1);
    tick();
    chk_state({tag, ".after"}, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pt_ready = 1'b0; use4 = 1'b1;
    set_coords(0, 0, 0, 0);
    tick();
    tick();
    chk_state("reset", 1'b0, 1'b0);
    chk({"reset", ".x8"}, 32'(ptx8), 32'(0));
    chk({"reset", ".idx8"}, 32'(idx8), 32'(0));
    chk({"reset", ".last4"}, 32'(last4), 32'(0));
    rst = 1'b0;
    tick();

    abort = 1'b1;
    start_line(0, 0, 3, 1);
    abort = 1'b0;
    chk_state("abort_idle", 1'b0, 1'b0);

    pt_ready = 1'b1;
    start_line(0, 0, 3, 1);
    xs = '{0, 1, 2, 3}; ys = '{0, 0, 1, 1};
    run4("shallow");

    start_line(0, 0, 1, 3);
    xs = '{0, 0, 1, 1}; ys = '{0, 1, 2, 3};
    run4("steep");

    pt_ready = 1'b0;
    start_line(5, 5, 2, 5);
    for (int k = 0; k < 4; k++) begin
      pt_ready = 1'b0;
      for (int s = 0; s < 2; s++) begin
        check_pt($sformatf("stall.p%0d.s%0d", k, s), 5 - k, 5, k, (k == 3));
        tick();
      end
      pt_ready = 1'b1;
      check_pt($sformatf("stall.p%0d.acc", k), 5 - k, 5, k, (k == 3));
      tick();
    end
    chk_state("stall.done", 1'b0, 1'b1);
    tick();

    start_line(7, 7, 7, 7);
    check_pt("degen", 7, 7, 0, 1'b1);
    tick();
    chk_state("degen.done", 1'b0, 1'b1);
    tick();
    chk_state("degen.after", 1'b0, 1'b0);

    start_line(0, 0, 15, 9);
    check_pt("abort.p0", 0, 0, 0, 1'b0);
    tick();
    check_pt("abort.p1", 1, 1, 1, 1'b0);
    start_line(9, 9, 9, 9);
    check_pt("busy_start.p2", 2, 1, 2, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_state("abort", 1'b0, 1'b0);
    tick();
    chk_state("abort.after", 1'b0, 1'b0);

    start_line(0, 0, 15, 9);
    tick();
    tick();
    check_pt("rst_mid.pre", 2, 1, 2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_state("rst_mid", 1'b0, 1'b0);
    chk({"rst_mid", ".x8"},   32'(ptx8),  32'(0));
    chk({"rst_mid", ".y4"},   32'(pty4),  32'(0));
    chk({"rst_mid", ".idx4"}, 32'(idx4),  32'(0));
    chk({"rst_mid", ".last8"}, 32'(last8), 32'(0));

    start_line(0, 0, 3, 1);
    xs = '{0, 1, 2, 3}; ys = '{0, 0, 1, 1};
    run4("restart");

    use4 = 1'b0;
    start_line(255, 0, 0, 255);
    for (int k = 0; k < 256; k++) begin
      check_pt($sformatf("span.p%0d", k), 255 - k, k, k, (k == 255));
      tick();
    end
    chk_state("span.done", 1'b0, 1'b1);
    tick();
    chk_state("span.after", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
